// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: shares one LCD character-driver command port between two
// requesters. Round-robin arbitration, single-cycle lcd_enable strobe, busy
// handshake tracking, done/err pulse back to the owning requester.
//
// Handshake contract (both requesters): reqN is a level request; gntN is a
// one-cycle pulse meaning cmdN has been captured and reqN may drop; doneN is
// a one-cycle pulse when the command finished, with err high in that same
// cycle if the driver never raised lcd_busy. To the driver, lcd_enable is a
// one-cycle strobe with lcd_bus valid only in that cycle; lcd_busy rising
// acknowledges it and lcd_busy falling marks completion.
//
// All outputs are registered: each pulse appears in the cycle after the
// state transition that produced it. dbg_state exposes the FSM state with
// the encoding WAIT_START=0, IDLE=1, ISSUE=2, ACK_WAIT=3, EXEC_WAIT=4.
module lcd_cmd_arbiter #(
  parameter int START_CYC = 8,
  parameter int TO_CYC    = 16,
  parameter int CBITS     = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [9:0] cmd0,
  output logic       gnt0,
  output logic       done0,
  input  logic       req1,
  input  logic [9:0] cmd1,
  output logic       gnt1,
  output logic       done1,
  output logic       err,
  input  logic       lcd_busy,
  output logic       lcd_enable,
  output logic [9:0] lcd_bus,
  output logic       active,
  output logic       owner,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_WAIT_START = 3'd0,
    S_IDLE       = 3'd1,
    S_ISSUE      = 3'd2,
    S_ACK_WAIT   = 3'd3,
    S_EXEC_WAIT  = 3'd4
  } state_t;

  localparam logic [CBITS-1:0] START_LAST = CBITS'(START_CYC - 1);
  localparam logic [CBITS-1:0] TO_LAST    = CBITS'(TO_CYC - 1);

  state_t           r_state, w_state;
  logic [CBITS-1:0] r_cnt, w_cnt;
  logic             r_rr_last, w_rr_last;
  logic [9:0]       r_cmd, w_cmd;
  logic             r_owner, w_owner;
  logic             r_gnt0, w_gnt0;
  logic             r_gnt1, w_gnt1;
  logic             r_done0, w_done0;
  logic             r_done1, w_done1;
  logic             r_err, w_err;
  logic             r_lcd_enable, w_lcd_enable;
  logic [9:0]       r_lcd_bus, w_lcd_bus;
  logic             r_active, w_active;
  logic             w_winner;

  // State, counter, latched command and all registered outputs; reset
  // aborts any in-flight command and forces the strobe low immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_WAIT_START;
      r_cnt        <= '0;
      r_rr_last    <= 1'b1;
      r_cmd        <= '0;
      r_owner      <= 1'b0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_err        <= 1'b0;
      r_lcd_enable <= 1'b0;
      r_lcd_bus    <= '0;
      r_active     <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_rr_last    <= w_rr_last;
      r_cmd        <= w_cmd;
      r_owner      <= w_owner;
      r_gnt0       <= w_gnt0;
      r_gnt1       <= w_gnt1;
      r_done0      <= w_done0;
      r_done1      <= w_done1;
      r_err        <= w_err;
      r_lcd_enable <= w_lcd_enable;
      r_lcd_bus    <= w_lcd_bus;
      r_active     <= w_active;
    end
  end

  // Next-state logic: arbitration, strobe, ack timeout and completion.
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_rr_last    = r_rr_last;
    w_cmd        = r_cmd;
    w_owner      = r_owner;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_done0      = 1'b0;
    w_done1      = 1'b0;
    w_err        = 1'b0;
    w_lcd_enable = 1'b0;
    w_lcd_bus    = '0;
    // A lone request always wins; a tie goes to whoever did not finish last.
    w_winner     = (req0 && req1) ? ~r_rr_last : req1;

    case (r_state)
      S_WAIT_START: begin
        // Driver busy is not trustworthy yet, so requests are ignored.
        if (r_cnt == START_LAST) begin
          w_cnt   = '0;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + CBITS'(1);
        end
      end
      S_IDLE: begin
        if (!lcd_busy && (req0 || req1)) begin
          w_cmd   = w_winner ? cmd1 : cmd0;
          w_gnt0  = ~w_winner;
          w_gnt1  = w_winner;
          w_owner = w_winner;
          w_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_lcd_enable = 1'b1;
        w_lcd_bus    = r_cmd;
        w_cnt        = '0;
        w_state      = S_ACK_WAIT;
      end
      S_ACK_WAIT: begin
        if (lcd_busy) begin
          w_state = S_EXEC_WAIT;
        end else if (r_cnt == TO_LAST) begin
          w_done0   = ~r_owner;
          w_done1   = r_owner;
          w_err     = 1'b1;
          w_rr_last = r_owner;
          w_state   = S_IDLE;
        end else begin
          w_cnt = r_cnt + CBITS'(1);
        end
      end
      S_EXEC_WAIT: begin
        // Execute time is bounded by the driver itself; no timeout here.
        if (!lcd_busy) begin
          w_done0   = ~r_owner;
          w_done1   = r_owner;
          w_rr_last = r_owner;
          w_state   = S_IDLE;
        end
      end
      default: begin
        w_cnt   = '0;
        w_state = S_WAIT_START;
      end
    endcase

    w_active = (w_state == S_ISSUE) || (w_state == S_ACK_WAIT) ||
               (w_state == S_EXEC_WAIT);
  end

  assign gnt0       = r_gnt0;
  assign gnt1       = r_gnt1;
  assign done0      = r_done0;
  assign done1      = r_done1;
  assign err        = r_err;
  assign lcd_enable = r_lcd_enable;
  assign lcd_bus    = r_lcd_bus;
  assign active     = r_active;
  assign owner      = r_owner;
  assign dbg_state  = r_state;

endmodule
